// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } pll_state_t;

   localparam int LOCK_CYCLES_DEF = 1024;
   localparam int HOLD_CYCLES_DEF = 16;
   localparam int DIV_SLOW_DEF    = 20;
   localparam int DIV_FAST_DEF    = 10;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_seq.sv
// Qualifies PLL lock, sequences the system reset release and generates the
// CPU clock-enable at a speed-selectable divide ratio.
module pll_reset_seq
   import pll_seq_pkg::*;
#(
   parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int DIV_SLOW    = DIV_SLOW_DEF,
   parameter int DIV_FAST    = DIV_FAST_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic pll_locked,
   input  logic speed_fast,
   input  logic lost_clr,
   output logic sys_rst,
   output logic cpu_ce,
   output logic ready,
   output logic lock_lost
);

   localparam int CNT_MAX = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
   localparam int DIV_W   = $clog2(DIV_MAX + 1);

   localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);

   logic             locked_s;
   pll_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [DIV_W-1:0] divcnt, divcnt_nxt;
   logic [DIV_W-1:0] div, div_nxt;
   logic [DIV_W-1:0] speed_div;
   logic             cpu_ce_nxt;
   logic             lock_lost_nxt;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   assign speed_div = speed_fast ? DIV_W'(DIV_FAST) : DIV_W'(DIV_SLOW);

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      divcnt_nxt    = '0;
      div_nxt       = div;
      cpu_ce_nxt    = 1'b0;
      lock_lost_nxt = lock_lost;

      // Losing lock in any qualified state overrides every other transition.
      case (state)
         WAIT_LOCK: begin
            if (locked_s) begin
               state_nxt = STABLE;
               cnt_nxt   = '0;
            end
         end
         STABLE: begin
            if (!locked_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt == LOCK_TC) begin
               state_nxt = HOLD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HOLD: begin
            if (!locked_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt == HOLD_TC) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
         end
      endcase

      // The ratio only changes at a period boundary so no enable period is
      // ever cut short or stretched.
      if (state_nxt == RUN) begin
         if (state != RUN) begin
            div_nxt = speed_div;
         end else if (divcnt == div - DIV_W'(1)) begin
            cpu_ce_nxt = 1'b1;
            div_nxt    = speed_div;
         end else begin
            divcnt_nxt = divcnt + DIV_W'(1);
         end
      end

      if (!locked_s && (state == HOLD || state == RUN)) begin
         lock_lost_nxt = 1'b1;
      end else if (lost_clr) begin
         lock_lost_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= WAIT_LOCK;
         cnt       <= '0;
         divcnt    <= '0;
         div       <= DIV_W'(DIV_SLOW);
         sys_rst   <= 1'b1;
         cpu_ce    <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         divcnt    <= divcnt_nxt;
         div       <= div_nxt;
         sys_rst   <= (state_nxt != RUN);
         cpu_ce    <= cpu_ce_nxt;
         lock_lost <= lock_lost_nxt;
      end
   end

   assign ready = (state == RUN);

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 The block SHALL have parameter LOCK_CYCLES, default 1024, the number of consecutive synchronized-lock cycles required before the hold phase.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 16, the number of extra cycles sys_rst stays asserted after lock qualifies.
REQ-003 The block SHALL have parameter DIV_SLOW, default 20, the clk divide ratio for the slow CPU enable (4 MHz from 80 MHz).
REQ-004 The block SHALL have parameter DIV_FAST, default 10, the clk divide ratio for the fast CPU enable (8 MHz from 80 MHz).
REQ-005 The block SHALL have port clk, input, 1, the single clock (80 MHz PLL output); there SHALL be no other clock.
REQ-006 The block SHALL have port rst, input, 1, reset; it SHALL be synchronous and active-high.
REQ-007 The block SHALL have port pll_locked, input, 1, the PLL lock status (asynchronous to clk).
REQ-008 The block SHALL have port speed_fast, input, 1, which selects DIV_FAST when 1 and DIV_SLOW when 0.
REQ-009 The block SHALL have port lost_clr, input, 1, which clears lock_lost.
REQ-010 The block SHALL have port sys_rst, output, 1, the system reset for downstream logic, active-high.
REQ-011 The block SHALL have port cpu_ce, output, 1, the single-cycle CPU clock-enable pulse.
REQ-012 The block SHALL have port ready, output, 1, which is high exactly when the state is RUN.
REQ-013 The block SHALL have port lock_lost, output, 1, a sticky flag indicating lock dropped after qualification.

Function
REQ-014 pll_locked SHALL pass through a 2-FF synchronizer, giving locked_s; no logic SHALL read pll_locked directly.
REQ-015 The state machine SHALL have the states WAIT_LOCK, STABLE, HOLD and RUN.
REQ-016 In WAIT_LOCK, the block SHALL move to STABLE with cnt=0 when locked_s=1.
REQ-017 In STABLE, cnt SHALL increment each cycle; at cnt==LOCK_CYCLES-1 the block SHALL go to HOLD with cnt=0.
REQ-018 In HOLD, cnt SHALL increment; at cnt==HOLD_CYCLES-1 the block SHALL go to RUN.
REQ-019 In STABLE, HOLD or RUN, if locked_s=0 the block SHALL go to WAIT_LOCK next cycle with cnt=0; this SHALL take priority over all other transitions.
REQ-020 sys_rst SHALL be 1 in every state except RUN, registered, and SHALL re-assert on the first cycle back in WAIT_LOCK.
REQ-021 cnt SHALL be sized for max(LOCK_CYCLES, HOLD_CYCLES) and SHALL never wrap.
REQ-022 Divider: outside RUN, divcnt SHALL be 0 and cpu_ce 0; in RUN, divcnt SHALL count 0..div-1 and wrap.
REQ-023 cpu_ce SHALL be 1 for exactly one cycle when divcnt==div-1.
REQ-024 The active divide ratio div SHALL be latched from speed_fast only on entry to RUN and at each divcnt wrap, so that no enable period is truncated or stretched.
REQ-025 The first cpu_ce after entering RUN SHALL occur div cycles after the first RUN cycle.
REQ-026 lock_lost SHALL set when locked_s=0 while in HOLD or RUN, and SHALL clear on lost_clr; set SHALL win when both occur in the same cycle.

Reset
REQ-027 On rst=1, the state SHALL go to WAIT_LOCK, cnt=0, divcnt=0, div=DIV_SLOW, both synchronizer FFs=0, sys_rst=1, cpu_ce=0, ready=0, lock_lost=0.
REQ-028 rst asserted mid-operation SHALL restart qualification from WAIT_LOCK regardless of locked_s.

Structure
REQ-029 Package pll_seq_pkg SHALL hold the state enum (WAIT_LOCK, STABLE, HOLD, RUN) and the default divide and cycle constants.
REQ-030 The synchronizer SHALL be the sub-module sync_2ff (1-bit, clk, rst), reusable elsewhere.
REQ-031 The block SHALL contain no combinational path from any input to any output.

Verification (LOCK_CYCLES=8, HOLD_CYCLES=4)
REQ-032 Bench SHALL check power-up: rst for 3 cycles, pll_locked=1 from the cycle rst falls -> sys_rst falls exactly 2+8+4=14 cycles later, ready rises in the same cycle, and lock_lost=0.
REQ-033 Bench SHALL check a glitch: pll_locked low for 1 cycle during STABLE at cnt=5 -> back to WAIT_LOCK, full 8+4 count restarts, and lock_lost stays 0.
REQ-034 Bench SHALL check loss in RUN: pll_locked falls -> sys_rst=1 and ready=0 within 3 cycles, lock_lost=1; lost_clr pulsed while lock is absent -> lock_lost stays 1; lost_clr pulsed later -> lock_lost clears.
REQ-035 Bench SHALL check speed: in RUN with speed_fast=0, cpu_ce period is 20; setting speed_fast=1 mid-period completes the 20-cycle period, after which the period is 10 with no period shorter than 10.
REQ-036 Bench SHALL check reset mid-RUN: rst for 1 cycle with locked held high -> sys_rst=1, cpu_ce=0 and divcnt=0, then sys_rst releases 14 cycles after rst deasserts.
